// File: rtl/a2_bus_pkg.sv
// a2_bus_pkg: phase constants and request record shared by the IIe aux bus master
package a2_bus_pkg;
  typedef logic [4:0] h_t;
  localparam h_t RAS_VID         = 5'd2;
  localparam h_t Q3_A_END        = 5'd3;
  localparam h_t CAS_VID         = 5'd4;
  localparam h_t PHI1_END        = 5'd6;
  localparam h_t CPU_START       = 5'd7;
  localparam h_t MD_ON           = 5'd8;
  localparam h_t RAS_CPU         = 5'd9;
  localparam h_t WE_ON           = 5'd9;
  localparam h_t Q3_B_END        = 5'd10;
  localparam h_t CAS_CPU         = 5'd11;
  localparam h_t MA_CPU_HI       = 5'd11;
  localparam h_t CPU_LAST_NORMAL = 5'd13;
  localparam h_t Q3_LONG_LO      = 5'd14;
  localparam h_t Q3_LONG_HI      = 5'd15;
  localparam int DEF_LONG_PERIOD = 65;
  localparam int DEF_LONG_EXTRA  = 2;
  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic        aux;
    logic [7:0]  wdata;
  } req_t;
  function automatic logic is_c07x(input logic [15:0] a);
    return a[15:4] == 12'hC07;
  endfunction
endpackage

// File: rtl/a2_phase_gen.sv
// a2_phase_gen: 14M phase counter, long-cycle counter and registered PHI0/PHI1/Q3
module a2_phase_gen
  import a2_bus_pkg::*;
#(
  parameter int LONG_PERIOD = DEF_LONG_PERIOD,
  parameter int LONG_EXTRA  = DEF_LONG_EXTRA
) (
  input  logic clk_i,
  input  logic rst_ni,
  output h_t   h_o,
  output h_t   h_next_o,
  output logic last_o,
  output logic phi0_o,
  output logic phi1_o,
  output logic q3_o
);
  localparam int CW = $clog2(LONG_PERIOD);
  localparam h_t LAST_LONG = h_t'(int'(CPU_LAST_NORMAL) + LONG_EXTRA);
  h_t h_q, h_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic long_q, long_d, phi0_q, phi0_d, phi1_q, phi1_d, q3_q, q3_d;
  // advance H and the cycle count; decode clock levels from the next H so the pins are glitch-free
  always_comb begin
    long_q = cyc_q == CW'(LONG_PERIOD - 1);
    last_o = h_q == (long_q ? LAST_LONG : CPU_LAST_NORMAL);
    h_d    = last_o ? '0 : h_q + 5'd1;
    cyc_d  = !last_o ? cyc_q : long_q ? '0 : cyc_q + CW'(1);
    long_d = cyc_d == CW'(LONG_PERIOD - 1);
    phi1_d = h_d <= PHI1_END;
    phi0_d = !phi1_d;
    q3_d   = h_d <= Q3_A_END || (h_d >= CPU_START && h_d <= Q3_B_END) ||
             (long_d && h_d >= Q3_LONG_LO && h_d <= Q3_LONG_HI);
  end
  // phase state and clock pin registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q    <= '0;
      cyc_q  <= '0;
      phi0_q <= 1'b0;
      phi1_q <= 1'b1;
      q3_q   <= 1'b1;
    end else begin
      h_q    <= h_d;
      cyc_q  <= cyc_d;
      phi0_q <= phi0_d;
      phi1_q <= phi1_d;
      q3_q   <= q3_d;
    end
  end
  assign h_o      = h_q;
  assign h_next_o = h_d;
  assign phi0_o   = phi0_q;
  assign phi1_o   = phi1_q;
  assign q3_o     = q3_q;
endmodule

// File: rtl/a2_aux_bus_master.sv
// a2_aux_bus_master: IIe-style aux slot initiator, one video fetch per PHI1 and one CPU access per PHI0
module a2_aux_bus_master
  import a2_bus_pkg::*;
#(
  parameter int LONG_PERIOD = DEF_LONG_PERIOD,
  parameter int LONG_EXTRA  = DEF_LONG_EXTRA
) (
  input  logic        C14M,
  input  logic        nRESET,
  output logic        PHI0,
  output logic        PHI1,
  output logic        Q3,
  output logic        nPRAS,
  output logic        nPCAS,
  output logic        nWE,
  output logic        nWE80,
  output logic        nEN80,
  output logic        nC07X,
  output logic [7:0]  MA,
  inout  wire  [7:0]  MD,
  input  logic [7:0]  VD,
  input  logic [15:0] vid_addr,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_aux,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic [7:0]  cpu_rdata,
  output logic [7:0]  vid_data,
  output logic        vid_valid
);
  h_t h, h_n;
  logic last, acc, cpu_h;
  logic act_q, act_d, ready_q, ready_d, oe_q, oe_d;
  logic ras_q, ras_d, cas_q, cas_d, we_q, we_d, we80_q, we80_d, en80_q, en80_d, c07_q, c07_d;
  logic done_q, vvalid_q;
  req_t req_q, req_d;
  logic [15:0] vid_q, vid_d, addr;
  logic [7:0] ma_q, ma_d, rdata_q, vdata_q;

  a2_phase_gen #(.LONG_PERIOD(LONG_PERIOD), .LONG_EXTRA(LONG_EXTRA)) u_phase (
    .clk_i(C14M), .rst_ni(nRESET), .h_o(h), .h_next_o(h_n), .last_o(last),
    .phi0_o(PHI0), .phi1_o(PHI1), .q3_o(Q3)
  );

  // handshake plus strobe/MA decode of the next H; idle PHI0 halves become dummy reads of $0000
  always_comb begin
    acc     = h == PHI1_END && cpu_req && ready_q;
    req_d   = acc ? req_t'{addr: cpu_addr, we: cpu_we, aux: cpu_aux, wdata: cpu_wdata} : req_q;
    act_d   = acc || (act_q && !last);
    ready_d = !acc && (ready_q || (last && act_q));
    cpu_h   = h_n >= CPU_START;
    addr    = act_d ? req_d.addr : 16'h0000;
    ras_d   = !((h_n >= RAS_VID && !cpu_h) || h_n >= RAS_CPU);
    cas_d   = !((h_n >= CAS_VID && !cpu_h) || h_n >= CAS_CPU);
    we_d    = !(act_d && req_d.we && h_n >= WE_ON);
    we80_d  = we_d || !req_d.aux;
    en80_d  = !(act_d && req_d.aux && cpu_h);
    c07_d   = !(act_d && cpu_h && is_c07x(addr));
    oe_d    = act_d && req_d.we && h_n >= MD_ON;
    ma_d    = h_n == '0 ? vid_addr[7:0] : h_n < CAS_VID ? vid_q[7:0] : !cpu_h ? vid_q[15:8] :
              h_n < MA_CPU_HI ? addr[7:0] : addr[15:8];
    vid_d   = h_n == '0 ? vid_addr : vid_q;
  end

  // pin registers, request record, and read/video data capture
  always_ff @(posedge C14M or negedge nRESET) begin
    if (!nRESET) begin
      act_q    <= 1'b0;
      ready_q  <= 1'b1;
      req_q    <= '0;
      vid_q    <= '0;
      ma_q     <= '0;
      oe_q     <= 1'b0;
      {ras_q, cas_q, we_q, we80_q, en80_q, c07_q} <= '1;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      vdata_q  <= '0;
      vvalid_q <= 1'b0;
    end else begin
      act_q    <= act_d;
      ready_q  <= ready_d;
      req_q    <= req_d;
      vid_q    <= vid_d;
      ma_q     <= ma_d;
      oe_q     <= oe_d;
      {ras_q, cas_q, we_q, we80_q, en80_q, c07_q} <= {ras_d, cas_d, we_d, we80_d, en80_d, c07_d};
      done_q   <= last && act_q;
      if (last && act_q && !req_q.we) rdata_q <= MD;
      vvalid_q <= h == PHI1_END;
      if (h == PHI1_END) vdata_q <= VD;
    end
  end

  assign MD        = oe_q ? req_q.wdata : 8'hzz;
  assign nPRAS     = ras_q;
  assign nPCAS     = cas_q;
  assign nWE       = we_q;
  assign nWE80     = we80_q;
  assign nEN80     = en80_q;
  assign nC07X     = c07_q;
  assign MA        = ma_q;
  assign cpu_ready = ready_q;
  assign cpu_done  = done_q;
  assign cpu_rdata = rdata_q;
  assign vid_data  = vdata_q;
  assign vid_valid = vvalid_q;
endmodule

// File: tb/tb_a2_aux_bus_master.sv
// tb_a2_aux_bus_master: cycle model of the IIe aux bus timing with directed CPU/video traffic
module tb_a2_aux_bus_master;
  logic C14M = 1'b0, nRESET = 1'b0;
  logic PHI0, PHI1, Q3, nPRAS, nPCAS, nWE, nWE80, nEN80, nC07X;
  logic [7:0] MA, VD, cpu_rdata, vid_data;
  wire  [7:0] MD;
  logic [15:0] vid_addr = 16'h2000, cpu_addr = 16'h0000;
  logic cpu_req = 1'b0, cpu_we = 1'b0, cpu_aux = 1'b0;
  logic [7:0] cpu_wdata = 8'h00, resp_val = 8'h00, card_bank = 8'h00;
  logic cpu_ready, cpu_done, vid_valid;
  int total = 0, passed = 0;

  a2_aux_bus_master dut (
    .C14M(C14M), .nRESET(nRESET), .PHI0(PHI0), .PHI1(PHI1), .Q3(Q3),
    .nPRAS(nPRAS), .nPCAS(nPCAS), .nWE(nWE), .nWE80(nWE80), .nEN80(nEN80), .nC07X(nC07X),
    .MA(MA), .MD(MD), .VD(VD), .vid_addr(vid_addr), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_aux(cpu_aux), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .vid_data(vid_data), .vid_valid(vid_valid)
  );

  always #5 C14M = ~C14M;

  // responder card: video data derived from the row/column address, CPU read data onto MD, bank register at $C07x
  assign VD = MA ^ 8'h5C;
  assign MD = (PHI0 && !nPCAS && nWE) ? (!nC07X ? card_bank : resp_val) : 8'hzz;
  always @(posedge C14M) if (!nWE && !nC07X) card_bank <= MD;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic c07(input logic [15:0] a);
    return a >= 16'hC070 && a <= 16'hC07F;
  endfunction

  // behavioural model: bus-cycle position and the access in flight
  int mh = 0, mcyc = 0, mlast;
  logic mact = 1'b0, m_we = 1'b0, m_aux = 1'b0, mdone = 1'b0, mvvalid = 1'b0;
  logic [15:0] m_addr = 16'h0, mvlat = 16'h0;
  logic [7:0] m_wd = 8'h0, mrdata = 8'h0, mvdata = 8'h0, mbank = 8'h0;

  initial forever begin
    @(posedge C14M or negedge nRESET);
    if (!nRESET) begin
      mh = 0; mcyc = 0; mact = 0; mdone = 0; mvvalid = 0; mvdata = 0; mrdata = 0; mvlat = 0;
    end else begin
      mlast = (mcyc == 64) ? 15 : 13;
      mdone = mact && mh == mlast;
      if (mdone && !m_we) mrdata = c07(m_addr) ? mbank : resp_val;
      if (mdone && m_we && c07(m_addr)) mbank = m_wd;
      mvvalid = mh == 6;
      if (mh == 6) mvdata = mvlat[15:8] ^ 8'h5C;
      if (mh == 6 && cpu_req) begin
        mact = 1; m_addr = cpu_addr; m_we = cpu_we; m_aux = cpu_aux; m_wd = cpu_wdata;
      end else if (mh == mlast) mact = 0;
      if (mh == mlast) begin
        mh = 0; mcyc = (mcyc == 64) ? 0 : mcyc + 1; mvlat = vid_addr;
      end else mh++;
    end
  end

  // every-cycle comparison of all pins against the model
  logic lng;
  logic [15:0] ca;
  logic [7:0] ema;
  logic [27:0] epins, apins;
  initial forever begin
    @(negedge C14M);
    lng = mcyc == 64;
    ca  = mact ? m_addr : 16'h0;
    ema = mh < 4 ? mvlat[7:0] : mh < 7 ? mvlat[15:8] : mh < 11 ? ca[7:0] : ca[15:8];
    epins = {mh >= 7, mh <= 6, mh <= 3 || (mh >= 7 && mh <= 10) || (lng && mh >= 14),
             !((mh >= 2 && mh <= 6) || mh >= 9), !((mh >= 4 && mh <= 6) || mh >= 11),
             !(mact && m_we && mh >= 9), !(mact && m_we && m_aux && mh >= 9),
             !(mact && m_aux), !(mact && c07(m_addr)), ema, !mact, mdone, mvvalid, mvdata};
    apins = {PHI0, PHI1, Q3, nPRAS, nPCAS, nWE, nWE80, nEN80, nC07X, MA,
             cpu_ready, cpu_done, vid_valid, vid_data};
    check("pins", 32'(apins), 32'(epins));
    if (mdone) check("rdata", 32'(cpu_rdata), 32'(mrdata));
    if (mact && m_we && mh >= 8) check("md_drive", 32'(MD), 32'(m_wd));
  end

  int r_en, r_we, r_we80, r_c07, r_ras, r_dh;
  logic [7:0] r_rd, r_ma_lo, r_ma_hi, r_md;

  task automatic xfer(input logic [15:0] a, input logic we, input logic aux,
                      input logic [7:0] wd, input logic [15:0] va);
    bit dn;
    cpu_addr = a; cpu_we = we; cpu_aux = aux; cpu_wdata = wd; vid_addr = va; cpu_req = 1'b1;
    r_en = 0; r_we = 0; r_we80 = 0; r_c07 = 0; r_ras = 0; r_dh = -1;
    r_rd = 0; r_ma_lo = 0; r_ma_hi = 0; r_md = 0; dn = 0;
    for (int i = 0; i < 80 && !dn; i++) begin
      @(negedge C14M);
      if (!cpu_ready) begin
        cpu_req = 1'b0;
        if (!nEN80) r_en++;
        if (!nWE) r_we++;
        if (!nWE80) r_we80++;
        if (!nC07X) r_c07++;
        if (!nPRAS) r_ras++;
        if (mh == 7) r_ma_lo = MA;
        if (mh == 11) r_ma_hi = MA;
        if (mh == 12) r_md = MD;
      end
      if (cpu_done) begin dn = 1; r_rd = cpu_rdata; r_dh = mh; end
    end
    check("done_seen", 32'(dn), 1);
    check("done_at_h0", 32'(r_dh), 0);
    cpu_req = 1'b0;
  endtask

  int clk_cnt, rises, p0, n7, n9, nd;
  bit prev, hit;
  initial begin
    #12;
    check("rst_clk", 32'({PHI0, PHI1, Q3}), 'b011);
    check("rst_strobes", 32'({nPRAS, nPCAS, nWE, nWE80, nEN80, nC07X}), 'h3F);
    check("rst_ma", 32'(MA), 0);
    check("rst_hs", 32'({cpu_ready, cpu_done, vid_valid}), 'b100);
    check("rst_data", 32'({vid_data, cpu_rdata}), 0);
    #15 nRESET = 1'b1;
    prev = 1; rises = 0; clk_cnt = 0; p0 = 0; n7 = 0; n9 = 0;
    while (rises < 65 && clk_cnt < 1000) begin
      @(posedge C14M); #1;
      clk_cnt++;
      if (PHI0) p0++;
      if (PHI1 && !prev) begin
        rises++;
        if (p0 == 7) n7++; else if (p0 == 9) n9++;
        p0 = 0;
      end
      prev = PHI1;
    end
    check("group_clocks", 32'(clk_cnt), 912);
    check("phi0_7_cycles", 32'(n7), 64);
    check("phi0_9_cycles", 32'(n9), 1);

    xfer(16'h1234, 1'b1, 1'b1, 8'hA5, 16'h4321);
    check("aw_ma_lo", 32'(r_ma_lo), 'h34);
    check("aw_ma_hi", 32'(r_ma_hi), 'h12);
    check("aw_we80", 32'(r_we80), 5);
    check("aw_md", 32'(r_md), 'hA5);
    check("aw_en80", 32'(r_en), 7);

    resp_val = 8'h5A;
    xfer(16'h0400, 1'b0, 1'b0, 8'h00, 16'h0800);
    check("mr_rdata", 32'(r_rd), 'h5A);
    check("mr_en80", 32'(r_en), 0);
    check("mr_we80", 32'(r_we80), 0);

    xfer(16'hC073, 1'b1, 1'b0, 8'h03, 16'h1C00);
    check("bw_c07x", 32'(r_c07), 7);
    check("bw_we", 32'(r_we), 5);
    check("bw_we80", 32'(r_we80), 0);
    xfer(16'hC073, 1'b0, 1'b0, 8'h00, 16'h1C01);
    check("br_rdata", 32'(r_rd), 3);
    check("br_c07x", 32'(r_c07), 7);

    xfer(16'h0500, 1'b1, 1'b0, 8'h3C, 16'h0401);
    check("mw_we", 32'(r_we), 5);
    check("mw_we80", 32'(r_we80), 0);

    for (int i = 0; i < 2000 && !(mcyc == 64 && mh == 0); i++) @(negedge C14M);
    check("long_sync", 32'(mcyc), 64);
    xfer(16'h3456, 1'b1, 1'b1, 8'hC3, 16'h2468);
    check("long_ras", 32'(r_ras), 7);
    check("long_we", 32'(r_we), 7);
    check("long_we80", 32'(r_we80), 7);
    check("long_wrap", 32'(mcyc), 0);

    cpu_addr = 16'h2000; cpu_we = 1'b1; cpu_aux = 1'b1; cpu_wdata = 8'h77; cpu_req = 1'b1; hit = 0;
    for (int i = 0; i < 80 && !hit; i++) begin
      @(negedge C14M);
      if (!cpu_ready) cpu_req = 1'b0;
      if (!cpu_ready && mh == 11) hit = 1;
    end
    check("rst_sync", 32'(hit), 1);
    check("pre_rst_we", 32'({nWE, nWE80, nEN80}), 0);
    #3 nRESET = 1'b0;
    #1;
    check("abort_strobes", 32'({nPRAS, nPCAS, nWE, nWE80, nEN80, nC07X}), 'h3F);
    check("abort_hs", 32'({cpu_ready, cpu_done}), 'b10);
    @(posedge C14M); #3 nRESET = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge C14M);
      if (cpu_done) nd++;
    end
    check("abort_no_done", 32'(nd), 0);
    check("abort_ready", 32'(cpu_ready), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
